// File: rtl/rename_free_list.sv
// Register-rename free list: a circular FIFO of free physical tags feeding two
// decode slots and refilled by up to two ROB commits per cycle.
module rename_free_list #(
  parameter int TAG_W    = 7,
  parameter int NUM_TAGS = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_req1,
  input  logic             alloc_req2,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag1,
  output logic [TAG_W-1:0] alloc_tag2,
  output logic             two_free,
  input  logic             release_en1,
  input  logic             release_en2,
  input  logic [TAG_W-1:0] release_tag1,
  input  logic [TAG_W-1:0] release_tag2,
  output logic [TAG_W:0]   free_count,
  output logic             rel_err
);

  localparam int CNT_W = TAG_W + 1;
  localparam int CW    = TAG_W + 2;
  localparam logic [CW-1:0] MAX_FREE = CW'(NUM_TAGS - 1);

  logic [TAG_W-1:0] fifo_q [NUM_TAGS];
  logic [TAG_W-1:0] fifo_d [NUM_TAGS];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rel_err_q, rel_err_d;

  logic [1:0]       need;
  logic [CW-1:0]    need_ext;
  logic [CW-1:0]    granted;
  logic [CW-1:0]    avail;
  logic [CW-1:0]    pushed;
  logic             rel1_ok;
  logic             rel2_ok;
  logic             rel_err_hit;
  logic [TAG_W-1:0] rel2_idx;

  // Tag 0 means "not renamed", so the initial free list is 1..NUM_TAGS-1.
  function automatic logic [TAG_W-1:0] init_tag(input int i);
    return (i < NUM_TAGS - 1) ? TAG_W'(i + 1) : '0;
  endfunction

  assign alloc_tag1 = fifo_q[head_q];
  assign alloc_tag2 = fifo_q[head_q + TAG_W'(1)];
  assign free_count = count_q;
  assign two_free   = (count_q >= CNT_W'(2));
  assign rel_err    = rel_err_q;

  assign need        = {1'b0, alloc_req1} + {1'b0, alloc_req2};
  assign need_ext    = CW'(need);
  assign alloc_grant = (need != 2'd0) && (need_ext <= CW'(count_q)) && !flush;
  assign granted     = alloc_grant ? need_ext : '0;
  assign avail       = CW'(count_q) - granted;

  // Overflow is judged on the post-grant count, release 1 before release 2.
  assign rel1_ok     = release_en1 && (release_tag1 != '0) && (avail < MAX_FREE);
  assign rel2_ok     = release_en2 && (release_tag2 != '0) &&
                       ((avail + CW'(rel1_ok)) < MAX_FREE);
  assign pushed      = CW'(rel1_ok) + CW'(rel2_ok);
  assign rel_err_hit = (release_en1 && !rel1_ok) || (release_en2 && !rel2_ok);
  assign rel2_idx    = rel1_ok ? tail_q + TAG_W'(1) : tail_q;

  always_comb begin
    fifo_d    = fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rel_err_d = rel_err_q;
    if (flush) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        fifo_d[i] = init_tag(i);
      end
      head_d  = '0;
      tail_d  = TAG_W'(NUM_TAGS - 1);
      count_d = CNT_W'(NUM_TAGS - 1);
    end else begin
      if (alloc_grant) begin
        head_d = head_q + TAG_W'(need);
      end
      if (rel1_ok) begin
        fifo_d[tail_q] = release_tag1;
      end
      if (rel2_ok) begin
        fifo_d[rel2_idx] = release_tag2;
      end
      tail_d  = tail_q + TAG_W'(pushed);
      count_d = CNT_W'(avail + pushed);
      if (rel_err_hit) begin
        rel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        fifo_q[i] <= init_tag(i);
      end
      head_q    <= '0;
      tail_q    <= TAG_W'(NUM_TAGS - 1);
      count_q   <= CNT_W'(NUM_TAGS - 1);
      rel_err_q <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rel_err_q <= rel_err_d;
    end
  end

endmodule

// File: tb/tb_rename_free_list.sv
// Self-checking bench for rename_free_list: directed vector table, corner-case
// sequences and a randomized run against a queue-based free-list model.
module tb_rename_free_list;

  localparam int TAG_W    = 7;
  localparam int NUM_TAGS = 128;
  localparam int MAXF     = NUM_TAGS - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             alloc_req1 = 1'b0;
  logic             alloc_req2 = 1'b0;
  logic             release_en1 = 1'b0;
  logic             release_en2 = 1'b0;
  logic [TAG_W-1:0] release_tag1 = '0;
  logic [TAG_W-1:0] release_tag2 = '0;
  logic             alloc_grant;
  logic [TAG_W-1:0] alloc_tag1;
  logic [TAG_W-1:0] alloc_tag2;
  logic             two_free;
  logic [TAG_W:0]   free_count;
  logic             rel_err;

  int n_checks = 0;
  int n_fail   = 0;

  int freeq[$];
  int outstanding[$];
  bit model_err = 1'b0;

  bit last_grant;
  int last_tag1;
  int last_tag2;

  typedef struct {
    bit r1; bit r2;
    bit e1; int t1;
    bit e2; int t2;
    bit exp_grant; int exp_tag1; int exp_tag2; int exp_count;
  } vec_t;
  vec_t vecs[7];

  rename_free_list #(.TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_req1(alloc_req1), .alloc_req2(alloc_req2),
    .alloc_grant(alloc_grant), .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
    .two_free(two_free),
    .release_en1(release_en1), .release_en2(release_en2),
    .release_tag1(release_tag1), .release_tag2(release_tag2),
    .free_count(free_count), .rel_err(rel_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    freeq.delete();
    outstanding.delete();
    for (int t = 1; t <= MAXF; t++) freeq.push_back(t);
  endtask

  function automatic int find_out(input int tag);
    foreach (outstanding[i]) if (outstanding[i] == tag) return i;
    return -1;
  endfunction

  task automatic model_release(input int tag);
    int idx;
    if (tag == 0 || freeq.size() + 1 > MAXF) begin
      model_err = 1'b1;
    end else begin
      freeq.push_back(tag);
      idx = find_out(tag);
      if (idx >= 0) outstanding.delete(idx);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic apply_stimulus(input bit f, input bit r1, input bit r2,
                                input bit e1, input int t1, input bit e2, input int t2);
    int  need;
    bit  exp_grant;
    flush        = f;
    alloc_req1   = r1;
    alloc_req2   = r2;
    release_en1  = e1;
    release_tag1 = t1[TAG_W-1:0];
    release_en2  = e2;
    release_tag2 = t2[TAG_W-1:0];
    #1;
    need      = int'(r1) + int'(r2);
    exp_grant = !f && need > 0 && need <= freeq.size();
    check_output("grant", int'(alloc_grant), int'(exp_grant));
    if (freeq.size() >= 1) check_output("tag1", int'(alloc_tag1), freeq[0]);
    if (freeq.size() >= 2) check_output("tag2", int'(alloc_tag2), freeq[1]);
    last_grant = alloc_grant;
    last_tag1  = int'(alloc_tag1);
    last_tag2  = int'(alloc_tag2);
    @(posedge clk);
    #1;
    if (f) begin
      model_init();
    end else begin
      if (exp_grant) begin
        for (int k = 0; k < need; k++) begin
          check_output("no_dup", find_out(k == 0 ? last_tag1 : last_tag2), -1);
          outstanding.push_back(freeq.pop_front());
        end
      end
      if (e1) model_release(t1);
      if (e2) model_release(t2);
    end
    check_output("free_count", int'(free_count), freeq.size());
    check_output("two_free", int'(two_free), int'(freeq.size() >= 2));
    check_output("rel_err", int'(rel_err), int'(model_err));
  endtask

  // Asserts reset wherever the caller is in the cycle and checks the reset view.
  task automatic do_reset();
    reset       = 1'b0;
    flush       = 1'b0;
    alloc_req1  = 1'b0;
    alloc_req2  = 1'b0;
    release_en1 = 1'b0;
    release_en2 = 1'b0;
    #1;
    check_output("rst_tag1", int'(alloc_tag1), 1);
    check_output("rst_tag2", int'(alloc_tag2), 2);
    check_output("rst_two_free", int'(two_free), 1);
    check_output("rst_grant", int'(alloc_grant), 0);
    check_output("rst_count", int'(free_count), MAXF);
    check_output("rst_rel_err", int'(rel_err), 0);
    model_init();
    model_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    int t1, t2, i, j;
    bit e1, e2;

    vecs[0] = '{1, 1, 0, 0, 0, 0, 1, 1, 2, 125};
    vecs[1] = '{1, 1, 0, 0, 0, 0, 1, 3, 4, 123};
    vecs[2] = '{1, 1, 0, 0, 0, 0, 1, 5, 6, 121};
    vecs[3] = '{0, 1, 0, 0, 0, 0, 1, 7, 8, 120};
    vecs[4] = '{1, 0, 0, 0, 0, 0, 1, 8, 9, 119};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 9, 10, 119};
    vecs[6] = '{1, 1, 0, 0, 0, 0, 1, 9, 10, 117};

    #3;
    do_reset();

    foreach (vecs[k]) begin
      apply_stimulus(0, vecs[k].r1, vecs[k].r2, vecs[k].e1, vecs[k].t1, vecs[k].e2, vecs[k].t2);
      check_output("vec_grant", int'(last_grant), int'(vecs[k].exp_grant));
      check_output("vec_tag1", last_tag1, vecs[k].exp_tag1);
      check_output("vec_tag2", last_tag2, vecs[k].exp_tag2);
      check_output("vec_count", int'(free_count), vecs[k].exp_count);
    end

    guard = 0;
    while (freeq.size() > 1 && guard < 200) begin
      if (freeq.size() >= 3) apply_stimulus(0, 1, 1, 0, 0, 0, 0);
      else apply_stimulus(0, 1, 0, 0, 0, 0, 0);
      guard++;
    end
    check_output("drain_to_one", int'(free_count), 1);

    apply_stimulus(0, 1, 1, 0, 0, 0, 0);
    check_output("one_left_pair_grant", int'(last_grant), 0);
    check_output("one_left_head_kept", int'(alloc_tag1), 127);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    check_output("last_grant", int'(last_grant), 1);
    check_output("last_tag", last_tag1, 127);
    check_output("empty_count", int'(free_count), 0);

    apply_stimulus(0, 1, 1, 1, 9, 1, 4);
    check_output("empty_no_bypass", int'(last_grant), 0);
    check_output("refill_tag1", int'(alloc_tag1), 9);
    check_output("refill_tag2", int'(alloc_tag2), 4);
    check_output("refill_count", int'(free_count), 2);

    for (int c = 0; c < 300; c++) begin
      e1 = 0; e2 = 0; t1 = 0; t2 = 0;
      if (outstanding.size() > 0 && ($urandom % 2) == 1) begin
        i = $urandom_range(outstanding.size() - 1, 0);
        t1 = outstanding[i];
        e1 = 1;
      end
      if (outstanding.size() > 1 && ($urandom % 2) == 1) begin
        do j = $urandom_range(outstanding.size() - 1, 0);
        while (e1 && outstanding[j] == t1);
        t2 = outstanding[j];
        e2 = 1;
      end
      apply_stimulus(0, 1'($urandom % 2), 1'($urandom % 2), e1, t1, e2, t2);
      check_output("count_range", int'(int'(free_count) <= MAXF), 1);
    end

    do_reset();
    apply_stimulus(0, 0, 0, 1, 5, 0, 0);
    check_output("overfull_err", int'(rel_err), 1);
    check_output("overfull_count", int'(free_count), MAXF);

    do_reset();
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    check_output("tag0_err", int'(rel_err), 1);
    apply_stimulus(1, 0, 0, 1, 7, 0, 0);
    check_output("err_through_flush", int'(rel_err), 1);
    check_output("flush_count", int'(free_count), MAXF);

    do_reset();
    for (int c = 0; c < 3; c++) apply_stimulus(0, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 1, 2, 1, 3);
    check_output("flush_grant", int'(last_grant), 0);
    check_output("flush_tag1", int'(alloc_tag1), 1);
    check_output("flush_count2", int'(free_count), MAXF);
    for (int c = 0; c < 3; c++) apply_stimulus(0, 1, 1, 0, 0, 0, 0);
    alloc_req1 = 1'b1;
    alloc_req2 = 1'b1;
    #3;
    do_reset();
    check_output("post_reset_tag1", int'(alloc_tag1), 1);
    check_output("post_reset_count", int'(free_count), MAXF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
